button_chord_encoder: RTL and testbench

Front end for the channel-strip pushbutton interface. Synchronises and debounces four raw active-low keys and accumulates a chord, meaning the set of keys held at any point during one press episode. On full release it emits the chord as a 4-bit button code, one clock wide. Its code output drives the 4-bit code input of the button-code decoder that sets mute, freqSelect, lowpassSelect and highpassSelect. Idle code is 0, so the decoder holds its state. Code 7 (mute toggle) toggles exactly once per chord.

---
 rtl/button_chord_encoder.sv | 131 +++++++++++++
 tb/tb_button_chord_encoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/button_chord_encoder.sv
// Pushbutton chord encoder: synchronises and debounces four active-low keys,
// accumulates every key held during one press episode, and on full release
// emits the chord as a one-clock button code followed by a holdoff gap.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no keys held, ready to start a new chord
// COLLECT | at least one key held, OR-ing every held key into the chord
// GAP     | code just emitted; wait out holdoff and a full release
module button_chord_encoder #(
    parameter int DEBOUNCE_CYCLES = 960000,
    parameter int HOLDOFF_CYCLES  = 2400000
) (
    input  logic       clk_48,
    input  logic       reset_n,
    input  logic [3:0] buttons_n,
    output logic [3:0] code,
    output logic       busy,
    output logic [3:0] debounced
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [HO_W-1:0] HO_DONE = HO_W'(HOLDOFF_CYCLES);
    localparam logic [HO_W-1:0] HO_ONE  = HO_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        GAP     = 2'd2
    } state_t;

    logic [3:0]      sync_a;
    logic [3:0]      sync_b;
    logic [3:0]      pressed;
    state_t          state;
    state_t          state_next;
    logic [3:0]      chord;
    logic [3:0]      chord_next;
    logic [3:0]      code_next;
    logic [HO_W-1:0] hold_cnt;
    logic [HO_W-1:0] hold_next;

    // Two-flop synchroniser; resets to the released level so no phantom press.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 4'hF;
            sync_b <= 4'hF;
        end else begin
            sync_a <= buttons_n;
            sync_b <= sync_a;
        end
    end

    assign pressed = ~sync_b;

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [DB_W-1:0] db_cnt;

        // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching clocks.
        always_ff @(posedge clk_48 or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt       <= '0;
                debounced[i] <= 1'b0;
            end else if (pressed[i] == debounced[i]) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                debounced[i] <= pressed[i];
                db_cnt       <= '0;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end
    end

    // Next-state and datapath decisions; code defaults to idle so it pulses one clock.
    always_comb begin
        state_next = state;
        chord_next = chord;
        code_next  = 4'h0;
        hold_next  = hold_cnt;
        case (state)
            IDLE: begin
                if (debounced != 4'h0) begin
                    chord_next = debounced;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                chord_next = chord | debounced;
                if (debounced == 4'h0) begin
                    code_next  = chord;
                    hold_next  = '0;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (hold_cnt != HO_DONE) begin
                    hold_next = hold_cnt + HO_ONE;
                end
                // A key still held after holdoff keeps us here until it is released.
                if ((hold_cnt == HO_DONE) && (debounced == 4'h0)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, chord, holdoff counter and registered outputs.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            chord    <= 4'h0;
            code     <= 4'h0;
            hold_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            chord    <= chord_next;
            code     <= code_next;
            hold_cnt <= hold_next;
            busy     <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_button_chord_encoder.sv
// Bench for button_chord_encoder: directed key sequences, a timeline model of
// the encoder checked every cycle, plus hand-computed literal expectations.
module tb_button_chord_encoder;

    localparam int D = 4;
    localparam int H = 8;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] buttons_n = 4'hF;
    logic [3:0] code;
    logic       busy;
    logic [3:0] debounced;

    int checks = 0;
    int passes = 0;
    logic [3:0] emitted [$];

    button_chord_encoder #(
        .DEBOUNCE_CYCLES(D),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk_48   (clk),
        .reset_n  (reset_n),
        .buttons_n(buttons_n),
        .code     (code),
        .busy     (busy),
        .debounced(debounced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: keys seen two clocks late; a key level is accepted once the last D
    // samples all disagree with the accepted level; an episode opens on the
    // first accepted key while not busy, closes on all-released, and busy ends
    // once more than H clocks have passed since the emit with no key held.
    logic [3:0] m_s1 = 4'h0;
    logic [3:0] m_s2 = 4'h0;
    logic [3:0] m_hist [D] = '{default: 4'h0};
    logic [3:0] m_deb = 4'h0;
    logic [3:0] m_chord = 4'h0;
    logic [3:0] m_code = 4'h0;
    bit         m_busy = 1'b0;
    bit         m_open = 1'b0;
    int         m_cyc = 0;
    int         m_emit_cyc = 0;
    logic [3:0] deb_pre;
    bit         busy_pre;
    bit         all_differ;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = 4'h0; m_s2 = 4'h0;
            for (int j = 0; j < D; j++) m_hist[j] = 4'h0;
            m_deb = 4'h0; m_chord = 4'h0; m_code = 4'h0;
            m_busy = 1'b0; m_open = 1'b0; m_cyc = 0; m_emit_cyc = 0;
        end else begin
            m_cyc++;
            deb_pre  = m_deb;
            busy_pre = m_busy;
            for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_s2;
            for (int i = 0; i < 4; i++) begin
                all_differ = 1'b1;
                for (int j = 0; j < D; j++) if (m_hist[j][i] == deb_pre[i]) all_differ = 1'b0;
                if (all_differ) m_deb[i] = ~deb_pre[i];
            end
            m_s2 = m_s1;
            m_s1 = ~buttons_n;
            m_code = 4'h0;
            if (!busy_pre && deb_pre != 4'h0) begin
                m_busy = 1'b1; m_open = 1'b1; m_chord = deb_pre;
            end else if (m_open) begin
                m_chord = m_chord | deb_pre;
                if (deb_pre == 4'h0) begin
                    m_code = m_chord; m_open = 1'b0; m_emit_cyc = m_cyc;
                end
            end else if (busy_pre && (m_cyc - m_emit_cyc) > H && deb_pre == 4'h0) begin
                m_busy = 1'b0;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_code", code, m_code);
        chk("cyc_busy", {3'b0, busy}, {3'b0, m_busy});
        chk("cyc_debounced", debounced, m_deb);
        if (code !== 4'h0) emitted.push_back(code);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_single(input string name, input logic [3:0] exp);
        chk({name, "_count"}, 4'(emitted.size()), 4'd1);
        chk({name, "_value"}, (emitted.size() > 0) ? emitted[0] : 4'h0, exp);
    endtask

    task automatic expect_idle(input string name);
        chk({name, "_code"}, code, 4'h0);
        chk({name, "_busy"}, {3'b0, busy}, 4'h0);
        chk({name, "_deb"}, debounced, 4'h0);
    endtask

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick(3);
        expect_idle("reset");

        // 1: reset mid-chord
        emitted.delete();
        buttons_n = 4'b0111;
        tick(10);
        chk("t1_pre_busy", {3'b0, busy}, 4'h1);
        chk("t1_pre_deb", debounced, 4'h8);
        #1 reset_n = 1'b0;
        #1 expect_idle("t1_assert");
        tick(3);
        expect_idle("t1_held");
        buttons_n = 4'hF;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        expect_idle("t1_release");
        tick(20);
        chk("t1_no_code", 4'(emitted.size()), 4'd0);

        // 2: single key timing
        emitted.delete();
        buttons_n = 4'b1110;
        tick(5);  chk("t2_deb_5", debounced, 4'h0);
        tick(1);  chk("t2_deb_6", debounced, 4'h1);
        tick(1);  chk("t2_busy_7", {3'b0, busy}, 4'h1);
        tick(13);
        buttons_n = 4'hF;
        tick(6);  chk("t2_code_6", code, 4'h0);
        tick(1);  chk("t2_code_7", code, 4'h1);
        tick(1);  chk("t2_code_8", code, 4'h0);
        tick(7);  chk("t2_busy_15", {3'b0, busy}, 4'h1);
        tick(1);  chk("t2_busy_16", {3'b0, busy}, 4'h0);
        expect_single("t2_emit", 4'd1);

        // 3: overlapping chord and the mute chord
        emitted.delete();
        buttons_n = 4'b1110; tick(10);
        buttons_n = 4'b0110; tick(10);
        buttons_n = 4'b0111; tick(10);
        buttons_n = 4'b1111; tick(25);
        expect_single("t3_chord9", 4'd9);
        emitted.delete();
        buttons_n = 4'b1000; tick(12);
        buttons_n = 4'b1111; tick(25);
        expect_single("t3_chord7", 4'd7);
        expect_idle("t3_end");

        // 4: short glitch is rejected
        emitted.delete();
        buttons_n = 4'b1011; tick(3);
        buttons_n = 4'b1111; tick(3);
        chk("t4_deb_edge", debounced, 4'h0);
        tick(12);
        expect_idle("t4_end");
        chk("t4_no_code", 4'(emitted.size()), 4'd0);

        // 5: press during the gap is discarded
        emitted.delete();
        buttons_n = 4'b1101; tick(12);
        buttons_n = 4'b1111;
        tick(7);  chk("t5_code", code, 4'h2);
        tick(2);
        buttons_n = 4'b1101;
        tick(30);
        chk("t5_held_deb", debounced, 4'h2);
        chk("t5_held_busy", {3'b0, busy}, 4'h1);
        buttons_n = 4'b1111;
        tick(6);  chk("t5_busy_6", {3'b0, busy}, 4'h1);
        tick(1);  chk("t5_busy_7", {3'b0, busy}, 4'h0);
        tick(5);
        expect_single("t5_emit", 4'd2);

        // 6: reset while a chord is collecting, keys held through reset
        emitted.delete();
        buttons_n = 4'b1100; tick(10);
        chk("t6_pre_busy", {3'b0, busy}, 4'h1);
        chk("t6_pre_deb", debounced, 4'h3);
        #1 reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(12);
        chk("t6_redeb", debounced, 4'h3);
        chk("t6_rebusy", {3'b0, busy}, 4'h1);
        chk("t6_no_abort_code", 4'(emitted.size()), 4'd0);
        buttons_n = 4'b1111;
        tick(25);
        expect_single("t6_emit", 4'd3);
        expect_idle("t6_end");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
